// File: rtl/loop_count_seq_if.sv
// loop_count_seq_if: bundles the loop sequencer's control, register-file and body handshake signals.
// Ports: start/body_ack/rd1/rd2 flow into the sequencer; a1/a2/a3/wd3/reg_write drive the register file;
//        body_req/busy/done/iter_count/wdog_err report loop progress. master = sequencer, slave = environment.
interface loop_count_seq_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          start;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          body_ack;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic          reg_write;
  logic          body_req;
  logic          busy;
  logic          done;
  logic [DW-1:0] iter_count;
  logic          wdog_err;

  modport master (
    input  start, rd1, rd2, body_ack,
    output a1, a2, a3, wd3, reg_write, body_req, busy, done, iter_count, wdog_err
  );

  modport slave (
    output start, rd1, rd2, body_ack,
    input  a1, a2, a3, wd3, reg_write, body_req, busy, done, iter_count, wdog_err
  );
endinterface

// File: rtl/loop_count_seq.sv
// loop_count_seq: loop sequencer wrapped around the count register file. Reads the iteration
// count (CNT_REG) and step (STEP_REG), runs one body_req/body_ack handshake per iteration, writes
// back the saturating decremented count and pulses done when it reaches zero.
// Ports: clk, rst (async, active-high), bus (loop_count_seq_if.master). All outputs registered.
// Optional macro LOOP_WDOG_EN: aborts with wdog_err after MAX_ITER iterations; otherwise wdog_err stays 0.
module loop_count_seq #(
  parameter int DW       = 16,
  parameter int AW       = 4,
  parameter int CNT_REG  = 0,
  parameter int STEP_REG = 1,
  parameter int MAX_ITER = 1024
) (
  input  logic              clk,
  input  logic              rst,
  loop_count_seq_if.master  bus
);

`ifdef LOOP_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_CAP, S_BODY, S_DEC, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic          reg_write_q, reg_write_d;
  logic          body_req_q, body_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] iter_q, iter_d;
  logic          wdog_q, wdog_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] step_q, step_d;

  logic [DW-1:0] next_cnt;
  logic [DW-1:0] iter_inc;

  // Saturating decrement: a step at or above the remaining count lands on zero, never wraps.
  assign next_cnt = (step_q >= cnt_q) ? '0 : (cnt_q - step_q);
  assign iter_inc = iter_q + DW'(1);

  always_comb begin
    state_d     = state_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    a3_d        = a3_q;
    wd3_d       = wd3_q;
    reg_write_d = 1'b0;
    body_req_d  = body_req_q;
    done_d      = 1'b0;
    iter_d      = iter_q;
    wdog_d      = wdog_q;
    cnt_d       = cnt_q;
    step_d      = step_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RD_ISSUE;
          iter_d  = '0;
          wdog_d  = 1'b0;
          a1_d    = AW'(CNT_REG);
          a2_d    = AW'(STEP_REG);
        end
      end
      // Addresses are already stable; the register file latches them on this cycle's negedge.
      S_RD_ISSUE: state_d = S_RD_CAP;
      S_RD_CAP: begin
        cnt_d  = bus.rd1;
        // A zero step would never terminate, so it is treated as a step of one.
        step_d = (bus.rd2 == '0) ? DW'(1) : bus.rd2;
        if (bus.rd1 == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_BODY;
          body_req_d = 1'b1;
        end
      end
      S_BODY: begin
        // Write port is set up on the way into DEC so reg_write is high exactly during DEC.
        if (bus.body_ack) begin
          state_d     = S_DEC;
          body_req_d  = 1'b0;
          reg_write_d = 1'b1;
          a3_d        = AW'(CNT_REG);
          wd3_d       = next_cnt;
        end
      end
      S_DEC: begin
        cnt_d  = next_cnt;
        iter_d = iter_inc;
        if (next_cnt == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (WDOG_EN && (iter_inc >= DW'(MAX_ITER))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          wdog_d  = 1'b1;
        end else begin
          state_d    = S_BODY;
          body_req_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a1_q        <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      wd3_q       <= '0;
      reg_write_q <= 1'b0;
      body_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      iter_q      <= '0;
      wdog_q      <= 1'b0;
      cnt_q       <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      reg_write_q <= reg_write_d;
      body_req_q  <= body_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      iter_q      <= iter_d;
      wdog_q      <= wdog_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
    end
  end

  assign bus.a1         = a1_q;
  assign bus.a2         = a2_q;
  assign bus.a3         = a3_q;
  assign bus.wd3        = wd3_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.body_req   = body_req_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.iter_count = iter_q;
  assign bus.wdog_err   = WDOG_EN & wdog_q;

endmodule
